// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: functional-unit class encodings, the
// func-to-class mapping and the fixed-width part of the dispatch record.
package tomasulo_pkg;

    localparam int FUNC_W = 4;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_MUL = 2'd1,
        CLS_BCH = 2'd2
    } fu_class_e;

    typedef struct packed {
        logic [1:0]        cls;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } disp_info_t;

    // Opcode class field value 3 has no unit of its own and runs on add/logic.
    function automatic logic [1:0] func_to_class(input logic [FUNC_W-1:0] func);
        logic [1:0] cls;
        cls = func[3:2];
        if (cls == 2'd3) begin
            cls = CLS_ADD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/issue_unit_param_rename_table.sv
// Register status table: per-register busy bit and producing ROB tag,
// with two lookup ports, an issue write port, commit clear and flush.
module rename_table
    import tomasulo_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int ROB_DEPTH = 8,
    localparam int RW = $clog2(NUM_REGS),
    localparam int TW = $clog2(ROB_DEPTH)
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic [RW-1:0] rd_addr1,
    input  logic [RW-1:0] rd_addr2,
    output logic          busy1,
    output logic          busy2,
    output logic [TW-1:0] tag1,
    output logic [TW-1:0] tag2,
    input  logic          issue_we,
    input  logic [RW-1:0] issue_rd,
    input  logic [TW-1:0] issue_tag,
    input  logic          commit_we,
    input  logic [RW-1:0] commit_rd,
    input  logic [TW-1:0] commit_tag,
    input  logic          flush
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [TW-1:0]       tag_q [NUM_REGS];
    logic [TW-1:0]       tag_d [NUM_REGS];

    // Lookups see the table as it stood before this cycle's updates.
    always_comb begin
        busy1 = busy_q[rd_addr1];
        busy2 = busy_q[rd_addr2];
        tag1  = tag_q[rd_addr1];
        tag2  = tag_q[rd_addr2];
    end

    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (commit_we && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag)) begin
                busy_d[commit_rd] = 1'b0;
            end
            // Issue is applied last so a same-register issue beats the commit clear.
            if (issue_we) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_tag;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: rtl/issue_unit_param.sv
// In-order issue stage: ROB allocation, per-class RS accounting, source
// renaming with CDB bypass, and a registered dispatch record.
module issue_unit_param
    import tomasulo_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int ROB_DEPTH    = 8,
    parameter int RS_PER_CLASS = 3,
    parameter int NUM_CLASSES  = 3,
    localparam int RW = $clog2(NUM_REGS),
    localparam int TW = $clog2(ROB_DEPTH)
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RW-1:0]          in_rs1,
    input  logic [RW-1:0]          in_rs2,
    input  logic [RW-1:0]          in_rd,
    input  logic [3:0]             in_func,
    input  logic [7:0]             in_addr,
    input  logic                   cdb_valid,
    input  logic [TW-1:0]          cdb_tag,
    input  logic                   commit_valid,
    input  logic [RW-1:0]          commit_rd,
    input  logic [NUM_CLASSES-1:0] rs_free,
    input  logic                   flush,
    output logic                   disp_valid,
    output logic [1:0]             disp_class,
    output logic [3:0]             disp_func,
    output logic [RW-1:0]          disp_rd,
    output logic [7:0]             disp_addr,
    output logic [TW-1:0]          disp_rob_tag,
    output logic                   disp_src1_rdy,
    output logic                   disp_src2_rdy,
    output logic [TW-1:0]          disp_src1_tag,
    output logic [TW-1:0]          disp_src2_tag,
    output logic [TW-1:0]          rob_head,
    output logic [TW:0]            rob_count,
    output logic                   rob_full,
    output logic                   rob_empty
);

    localparam int CW = $clog2(RS_PER_CLASS + 1);

    logic [TW-1:0] head_q, head_d;
    logic [TW-1:0] tail_q, tail_d;
    logic [TW:0]   count_q, count_d;
    logic [CW-1:0] rs_cnt_q [NUM_CLASSES];
    logic [CW-1:0] rs_cnt_d [NUM_CLASSES];

    logic          disp_valid_q, disp_valid_d;
    disp_info_t    disp_info_q, disp_info_d;
    logic [RW-1:0] disp_rd_q, disp_rd_d;
    logic [TW-1:0] disp_rob_tag_q, disp_rob_tag_d;
    logic          disp_src1_rdy_q, disp_src1_rdy_d;
    logic          disp_src2_rdy_q, disp_src2_rdy_d;
    logic [TW-1:0] disp_src1_tag_q, disp_src1_tag_d;
    logic [TW-1:0] disp_src2_tag_q, disp_src2_tag_d;

    logic [1:0]    in_cls;
    logic          rs_avail;
    logic          full;
    logic          fire;
    logic          commit_ok;
    logic          src1_busy, src2_busy;
    logic [TW-1:0] src1_tag, src2_tag;

    rename_table #(
        .NUM_REGS  (NUM_REGS),
        .ROB_DEPTH (ROB_DEPTH)
    ) u_rename_table (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .rd_addr1   (in_rs1),
        .rd_addr2   (in_rs2),
        .busy1      (src1_busy),
        .busy2      (src2_busy),
        .tag1       (src1_tag),
        .tag2       (src2_tag),
        .issue_we   (fire),
        .issue_rd   (in_rd),
        .issue_tag  (tail_q),
        .commit_we  (commit_ok),
        .commit_rd  (commit_rd),
        .commit_tag (head_q),
        .flush      (flush)
    );

    always_comb begin
        in_cls   = func_to_class(in_func);
        rs_avail = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (in_cls == 2'(c)) begin
                rs_avail = (rs_cnt_q[c] < CW'(RS_PER_CLASS));
            end
        end
        full      = (count_q == (TW+1)'(ROB_DEPTH));
        in_ready  = !flush && !full && rs_avail;
        fire      = in_valid && in_ready;
        commit_ok = commit_valid && (count_q != '0) && !flush;
    end

    // A release and an allocation in the same class cancel out; a release
    // against an empty counter is dropped.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rs_cnt_d = rs_cnt_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                rs_cnt_d[c] = '0;
            end
        end else begin
            head_d  = head_q + TW'(commit_ok);
            tail_d  = tail_q + TW'(fire);
            count_d = count_q + (TW+1)'(fire) - (TW+1)'(commit_ok);
            for (int c = 0; c < NUM_CLASSES; c++) begin
                rs_cnt_d[c] = rs_cnt_q[c]
                            + CW'(fire && (in_cls == 2'(c)))
                            - CW'(rs_free[c] && (rs_cnt_q[c] != '0));
            end
        end
    end

    always_comb begin
        disp_valid_d    = fire;
        disp_info_d     = disp_info_q;
        disp_rd_d       = disp_rd_q;
        disp_rob_tag_d  = disp_rob_tag_q;
        disp_src1_rdy_d = disp_src1_rdy_q;
        disp_src2_rdy_d = disp_src2_rdy_q;
        disp_src1_tag_d = disp_src1_tag_q;
        disp_src2_tag_d = disp_src2_tag_q;
        if (fire) begin
            disp_info_d.cls  = in_cls;
            disp_info_d.func = in_func;
            disp_info_d.addr = in_addr;
            disp_rd_d        = in_rd;
            disp_rob_tag_d   = tail_q;
            disp_src1_rdy_d  = !src1_busy || (cdb_valid && (cdb_tag == src1_tag));
            disp_src2_rdy_d  = !src2_busy || (cdb_valid && (cdb_tag == src2_tag));
            disp_src1_tag_d  = src1_tag;
            disp_src2_tag_d  = src2_tag;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                rs_cnt_q[c] <= '0;
            end
            disp_valid_q    <= 1'b0;
            disp_info_q     <= '0;
            disp_rd_q       <= '0;
            disp_rob_tag_q  <= '0;
            disp_src1_rdy_q <= 1'b0;
            disp_src2_rdy_q <= 1'b0;
            disp_src1_tag_q <= '0;
            disp_src2_tag_q <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            rs_cnt_q        <= rs_cnt_d;
            disp_valid_q    <= disp_valid_d;
            disp_info_q     <= disp_info_d;
            disp_rd_q       <= disp_rd_d;
            disp_rob_tag_q  <= disp_rob_tag_d;
            disp_src1_rdy_q <= disp_src1_rdy_d;
            disp_src2_rdy_q <= disp_src2_rdy_d;
            disp_src1_tag_q <= disp_src1_tag_d;
            disp_src2_tag_q <= disp_src2_tag_d;
        end
    end

    assign disp_valid    = disp_valid_q;
    assign disp_class    = disp_info_q.cls;
    assign disp_func     = disp_info_q.func;
    assign disp_addr     = disp_info_q.addr;
    assign disp_rd       = disp_rd_q;
    assign disp_rob_tag  = disp_rob_tag_q;
    assign disp_src1_rdy = disp_src1_rdy_q;
    assign disp_src2_rdy = disp_src2_rdy_q;
    assign disp_src1_tag = disp_src1_tag_q;
    assign disp_src2_tag = disp_src2_tag_q;
    assign rob_head      = head_q;
    assign rob_count     = count_q;
    assign rob_full      = full;
    assign rob_empty     = (count_q == '0);

endmodule
